// File: rtl/l2sw_pkg.sv
// rtl/l2sw_pkg.sv - XGMII control characters and idle word shared by the patch matrix
package l2sw_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;

  // {txc, txd}: all lanes control, all lanes idle
  localparam logic [71:0] XGMII_IDLE_WORD = {8'hFF, {8{XGMII_IDLE}}};

  function automatic logic lane_is(input logic [63:0] d, input logic [7:0] c,
                                   input logic [2:0] lane, input logic [7:0] ch);
    return c[lane] && (d[{lane, 3'b000} +: 8] == ch);
  endfunction

endpackage

// File: rtl/xgmii_frame_tracker.sv
// rtl/xgmii_frame_tracker.sv - per-RX-port frame state and quiescence; optional counters under L2SW_FRAME_COUNT_EN
module xgmii_frame_tracker
  import l2sw_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      rxd,
  input  logic [7:0]       rxc,
`ifdef L2SW_FRAME_COUNT_EN
  output logic [CNT_W-1:0] frames,
  output logic [CNT_W-1:0] errors,
`endif
  output logic             quiet
);

  logic [7:0] term_lane;
  logic [7:0] err_lane;
  logic       start0;
  logic       start4;
  logic       any_term;
  logic       start_after_term;
  logic       in_frame_q;
  logic       in_frame_nxt;

  always_comb begin
    term_lane = '0;
    err_lane  = '0;
    for (int k = 0; k < 8; k++) begin
      term_lane[k] = lane_is(rxd, rxc, 3'(k), XGMII_TERM);
      err_lane[k]  = lane_is(rxd, rxc, 3'(k), XGMII_ERR);
    end
    start0   = lane_is(rxd, rxc, 3'd0, XGMII_START);
    start4   = lane_is(rxd, rxc, 3'd4, XGMII_START);
    any_term = |term_lane;
    // A lane cannot hold START and TERM at once, so lane-0 START is "after" only with no TERM,
    // and lane-4 START is "after" unless a TERM sits in lanes 5..7.
    start_after_term = (start4 && !(|term_lane[7:5])) || (start0 && !any_term);
    if (start_after_term)
      in_frame_nxt = 1'b1;
    else if (any_term)
      in_frame_nxt = 1'b0;
    else
      in_frame_nxt = in_frame_q;
    quiet = !in_frame_q && !(start0 || start4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      in_frame_q <= 1'b0;
    else
      in_frame_q <= in_frame_nxt;
  end

`ifdef L2SW_FRAME_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]     n_start;
  logic [CNT_W:0] frames_sum;

  always_comb begin
    n_start    = {1'b0, start0} + {1'b0, start4};
    frames_sum = {1'b0, frames} + (CNT_W+1)'(n_start);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames <= '0;
      errors <= '0;
    end else begin
      frames <= frames_sum[CNT_W] ? CNT_MAX : frames_sum[CNT_W-1:0];
      if ((|err_lane) && (errors != CNT_MAX))
        errors <= errors + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/xgmii_patch_matrix.sv
// rtl/xgmii_patch_matrix.sv - N-port XGMII patch matrix, frame-boundary switching; counters under L2SW_FRAME_COUNT_EN
module xgmii_patch_matrix
  import l2sw_pkg::*;
#(
  parameter  int NPORTS = 4,
  parameter  int CNT_W  = 32,
  localparam int SEL_W  = $clog2(NPORTS)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NPORTS*64-1:0]    xgmii_rxd,
  input  logic [NPORTS*8-1:0]     xgmii_rxc,
  output logic [NPORTS*64-1:0]    xgmii_txd,
  output logic [NPORTS*8-1:0]     xgmii_txc,
  input  logic [NPORTS*SEL_W-1:0] map_sel,
  input  logic [NPORTS-1:0]       port_en,
`ifdef L2SW_FRAME_COUNT_EN
  output logic [NPORTS*CNT_W-1:0] rx_frames,
  output logic [NPORTS*CNT_W-1:0] rx_errors,
`endif
  output logic [NPORTS*SEL_W-1:0] map_active,
  output logic [NPORTS-1:0]       en_active
);

  localparam int NSLOT = 1 << SEL_W;

  function automatic logic [NPORTS*SEL_W-1:0] pair_swap_map();
    logic [NPORTS*SEL_W-1:0] m;
    m = '0;
    for (int t = 0; t < NPORTS; t++)
      m[t*SEL_W +: SEL_W] = SEL_W'(t ^ 1);
    return m;
  endfunction

  localparam logic [NPORTS*SEL_W-1:0] RST_MAP = pair_swap_map();

  logic [NPORTS-1:0]       quiet;
  logic [NSLOT-1:0]        quiet_pad;
  logic [71:0]             rx_word [NSLOT];
  logic [NPORTS*SEL_W-1:0] map_nxt;
  logic [NPORTS-1:0]       en_nxt;
  logic [NPORTS-1:0]       commit;
  logic [NPORTS*72-1:0]    tx_nxt;

  for (genvar p = 0; p < NPORTS; p++) begin : g_rx
    xgmii_frame_tracker #(.CNT_W(CNT_W)) u_trk (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .rxd    (xgmii_rxd[p*64 +: 64]),
      .rxc    (xgmii_rxc[p*8 +: 8]),
`ifdef L2SW_FRAME_COUNT_EN
      .frames (rx_frames[p*CNT_W +: CNT_W]),
      .errors (rx_errors[p*CNT_W +: CNT_W]),
`endif
      .quiet  (quiet[p])
    );
  end

  // Pad to a power of two so selector-indexed lookups never leave the array
  always_comb begin
    quiet_pad = '0;
    quiet_pad[NPORTS-1:0] = quiet;
    for (int s = 0; s < NSLOT; s++)
      rx_word[s] = XGMII_IDLE_WORD;
    for (int p = 0; p < NPORTS; p++)
      rx_word[p] = {xgmii_rxc[p*8 +: 8], xgmii_rxd[p*64 +: 64]};
  end

  always_comb begin
    map_nxt = map_active;
    en_nxt  = en_active;
    commit  = '0;
    tx_nxt  = '0;
    for (int t = 0; t < NPORTS; t++) begin
      commit[t] = (int'(map_sel[t*SEL_W +: SEL_W]) < NPORTS)
               && ((map_sel[t*SEL_W +: SEL_W] != map_active[t*SEL_W +: SEL_W])
                   || (port_en[t] != en_active[t]))
               && quiet_pad[map_active[t*SEL_W +: SEL_W]]
               && quiet_pad[map_sel[t*SEL_W +: SEL_W]];
      if (commit[t]) begin
        map_nxt[t*SEL_W +: SEL_W] = map_sel[t*SEL_W +: SEL_W];
        en_nxt[t]                 = port_en[t];
      end
      // The word launched this cycle already follows the newly committed mapping
      tx_nxt[t*72 +: 72] = en_nxt[t] ? rx_word[map_nxt[t*SEL_W +: SEL_W]] : XGMII_IDLE_WORD;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      map_active <= RST_MAP;
      en_active  <= '1;
      xgmii_txd  <= {NPORTS{XGMII_IDLE_WORD[63:0]}};
      xgmii_txc  <= '1;
    end else begin
      map_active <= map_nxt;
      en_active  <= en_nxt;
      for (int t = 0; t < NPORTS; t++)
        {xgmii_txc[t*8 +: 8], xgmii_txd[t*64 +: 64]} <= tx_nxt[t*72 +: 72];
    end
  end

endmodule
